servo_slew_ctrl: RTL and testbench

SERVO_SLEW_CTRL -- requirements
Module: servo_slew_ctrl

---
 rtl/servo_pkg.sv | 15 +
 rtl/servo_slew_ctrl_if.sv | 21 ++
 rtl/servo_step_unit.sv | 34 +++
 rtl/servo_slew_ctrl.sv | 156 +++++++++++++++
 tb/tb_servo_slew_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants, width type and FSM states for the servo slew controller
package servo_pkg;

   localparam int SERVO_MIN_US    = 1000;
   localparam int SERVO_MAX_US    = 2000;
   localparam int SERVO_CENTER_US = 1500;

   typedef logic [15:0] width_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/servo_slew_ctrl_if.sv
// rtl/servo_slew_ctrl_if.sv - command handshake bundle for the servo slew controller
interface servo_slew_ctrl_if;
   import servo_pkg::*;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_ch;
   width_t     cmd_width;
   logic       cmd_err;

   modport master (
      output cmd_valid, cmd_ch, cmd_width,
      input  cmd_ready, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_ch, cmd_width,
      output cmd_ready, cmd_err
   );

endinterface

// File: rtl/servo_step_unit.sv
// rtl/servo_step_unit.sv - one slew step of a width toward its target, never overshooting
module servo_step_unit
   import servo_pkg::*;
#(
   parameter int STEP_US = 10
) (
   input  width_t cur,
   input  width_t tgt,
   output width_t nxt
);

   logic [16:0] cur_x;
   logic [16:0] tgt_x;
   logic [16:0] step_x;
   logic [16:0] diff;

   assign cur_x  = {1'b0, cur};
   assign tgt_x  = {1'b0, tgt};
   assign step_x = 17'(STEP_US);

   // Distance is checked before stepping, so the 17-bit result cannot wrap
   always_comb begin
      nxt  = cur;
      diff = '0;
      if (cur_x < tgt_x) begin
         diff = tgt_x - cur_x;
         nxt  = (diff > step_x) ? width_t'(cur_x + step_x) : tgt;
      end else if (cur_x > tgt_x) begin
         diff = cur_x - tgt_x;
         nxt  = (diff > step_x) ? width_t'(cur_x - step_x) : tgt;
      end
   end

endmodule

// File: rtl/servo_slew_ctrl.sv
// rtl/servo_slew_ctrl.sv - multi-channel servo width slew limiter; SERVO_SLEW_CLAMP_EN clamps out-of-range commands
module servo_slew_ctrl
   import servo_pkg::*;
#(
   parameter int NUM_CH    = 5,
   parameter int STEP_US   = 10,
   parameter int MIN_US    = SERVO_MIN_US,
   parameter int MAX_US    = SERVO_MAX_US,
   parameter int CENTER_US = SERVO_CENTER_US
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   servo_slew_ctrl_if.slave         cmd,
   output logic [NUM_CH-1:0][15:0]  width_us,
   output logic [NUM_CH-1:0]        settled,
   output logic                     busy
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   width_t             cur_q [NUM_CH];
   width_t             cur_d [NUM_CH];
   width_t             tgt_q [NUM_CH];
   width_t             tgt_d [NUM_CH];
   logic [NUM_CH-1:0]  settled_q, settled_d;
   logic               err_q, err_d;

   logic               accept;
   logic               ch_ok;
   logic               width_ok;
   width_t             wr_val;
   width_t             step_cur;
   width_t             step_tgt;
   width_t             step_nxt;

   servo_step_unit #(.STEP_US(STEP_US)) u_step (
      .cur (step_cur),
      .tgt (step_tgt),
      .nxt (step_nxt)
   );

   // Select the channel being scanned for the shared step unit
   always_comb begin
      step_cur = cur_q[0];
      step_tgt = tgt_q[0];
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(idx_q) == i) begin
            step_cur = cur_q[i];
            step_tgt = tgt_q[i];
         end
      end
   end

   // Command legality: channel range, then width range (clamped or rejected)
   always_comb begin
      accept = cmd.cmd_valid && (state_q == IDLE);
      ch_ok  = int'(cmd.cmd_ch) < NUM_CH;
`ifdef SERVO_SLEW_CLAMP_EN
      width_ok = 1'b1;
      if (17'(cmd.cmd_width) < 17'(MIN_US))
         wr_val = width_t'(MIN_US);
      else if (17'(cmd.cmd_width) > 17'(MAX_US))
         wr_val = width_t'(MAX_US);
      else
         wr_val = cmd.cmd_width;
`else
      width_ok = (17'(cmd.cmd_width) >= 17'(MIN_US)) && (17'(cmd.cmd_width) <= 17'(MAX_US));
      wr_val   = cmd.cmd_width;
`endif
   end

   // Next-state, target writes and per-cycle channel update
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      err_d   = 1'b0;

      if (accept) begin
         if (ch_ok && width_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (int'(cmd.cmd_ch) == i)
                  tgt_d[i] = wr_val;
            end
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (int'(idx_q) == i)
                  cur_d[i] = step_nxt;
            end
            if (int'(idx_q) == NUM_CH - 1) begin
               state_d = IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase

      for (int i = 0; i < NUM_CH; i++)
         settled_d[i] = (cur_q[i] == tgt_q[i]);
   end

   // State registers; reset recentres every channel and aborts any scan
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         settled_q <= '1;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cur_q[i] <= width_t'(CENTER_US);
            tgt_q[i] <= width_t'(CENTER_US);
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         settled_q <= settled_d;
         err_q     <= err_d;
         cur_q     <= cur_d;
         tgt_q     <= tgt_d;
      end
   end

   // Output drive
   always_comb begin
      width_us = '0;
      for (int i = 0; i < NUM_CH; i++)
         width_us[i] = cur_q[i];
   end

   assign settled       = settled_q;
   assign busy          = (state_q == SCAN);
   assign cmd.cmd_ready = (state_q == IDLE);
   assign cmd.cmd_err   = err_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// tb/tb_servo_slew_ctrl.sv - randomized self-checking bench for servo_slew_ctrl against a frame-level model
module tb_servo_slew_ctrl;

   localparam int NUM_CH = 5;
   localparam int STEP   = 10;
   localparam int MIN_W  = 1000;
   localparam int MAX_W  = 2000;
   localparam int CTR_W  = 1500;

   logic                    clk;
   logic                    rst;
   logic                    tick;
   logic [NUM_CH-1:0][15:0] width_us;
   logic [NUM_CH-1:0]       settled;
   logic                    busy;

   servo_slew_ctrl_if cmd_if ();

   servo_slew_ctrl #(
      .NUM_CH    (NUM_CH),
      .STEP_US   (STEP),
      .MIN_US    (MIN_W),
      .MAX_US    (MAX_W),
      .CENTER_US (CTR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .cmd      (cmd_if),
      .width_us (width_us),
      .settled  (settled),
      .busy     (busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int m_cur [NUM_CH];
   int m_tgt [NUM_CH];

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_cur[i] = CTR_W;
         m_tgt[i] = CTR_W;
      end
   endtask

   // One whole frame: every channel slews toward its target by at most STEP
   task automatic model_tick();
      for (int i = 0; i < NUM_CH; i++) begin
         if (m_cur[i] < m_tgt[i])
            m_cur[i] = (m_cur[i] + STEP < m_tgt[i]) ? m_cur[i] + STEP : m_tgt[i];
         else if (m_cur[i] > m_tgt[i])
            m_cur[i] = (m_cur[i] - STEP > m_tgt[i]) ? m_cur[i] - STEP : m_tgt[i];
      end
   endtask

   task automatic model_cmd(input int ch, input int w, output int exp_err);
      exp_err = 0;
      if (ch >= NUM_CH) begin
         exp_err = 1;
      end else if (w < MIN_W || w > MAX_W) begin
`ifdef SERVO_SLEW_CLAMP_EN
         m_tgt[ch] = (w < MIN_W) ? MIN_W : MAX_W;
`else
         exp_err = 1;
`endif
      end else begin
         m_tgt[ch] = w;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("%s_w%0d", tag, i), int'(width_us[i]), m_cur[i]);
         check($sformatf("%s_s%0d", tag, i), int'(settled[i]), (m_cur[i] == m_tgt[i]) ? 1 : 0);
      end
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_rdy"}, int'(cmd_if.cmd_ready), 1);
   endtask

   task automatic finish_scan(input string tag);
      int n = 0;
      while (busy && n < 50) begin
         n++;
         @(posedge clk); #1;
      end
      check({tag, "_busy_len"}, n, NUM_CH);
      model_tick();
      @(posedge clk); #1;
      check_all(tag);
   endtask

   task automatic do_tick(input string tag);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      finish_scan(tag);
   endtask

   task automatic run_cmd(input string tag, input int ch, input int w, input bit with_tick);
      int exp_err;
      int guard = 0;
      while (!cmd_if.cmd_ready && guard < 50) begin
         guard++;
         @(posedge clk); #1;
      end
      check({tag, "_rdy_wait"}, int'(cmd_if.cmd_ready), 1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_ch    = 3'(ch);
      cmd_if.cmd_width = 16'(w);
      tick             = with_tick;
      @(posedge clk); #1;
      cmd_if.cmd_valid = 1'b0;
      tick             = 1'b0;
      model_cmd(ch, w, exp_err);
      check({tag, "_err"}, int'(cmd_if.cmd_err), exp_err);
      if (with_tick) begin
         finish_scan(tag);
      end else begin
         @(posedge clk); #1;
         check({tag, "_err_clr"}, int'(cmd_if.cmd_err), 0);
         check_all(tag);
      end
   endtask

   initial begin
      int guard;
      rst              = 1'b1;
      tick             = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_ch    = '0;
      cmd_if.cmd_width = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      check("reset_err", int'(cmd_if.cmd_err), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Idle ticks leave everything centred
      for (int t = 0; t < 3; t++) do_tick("idle_tick");

      // Slew up by 10 per frame to 1600
      run_cmd("ch2_up", 2, 1600, 0);
      for (int t = 0; t < 10; t++) do_tick("ch2_tick");

      // Slew down to 1005 with no overshoot on the last step
      run_cmd("ch0_dn", 0, 1005, 0);
      for (int t = 0; t < 50; t++) do_tick("ch0_tick");

      // Illegal channel and out-of-range width
      run_cmd("bad_ch", 6, 1200, 0);
      run_cmd("bad_w", 1, 2500, 0);
      for (int t = 0; t < 3; t++) do_tick("bad_tick");

      // Command with a simultaneous tick uses the new target in that scan
      run_cmd("cmd_tick", 3, 1350, 1);

      // Tick and held command during a scan
      tick = 1'b1;
      @(posedge clk); #1;
      tick             = 1'b0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_ch    = 3'd4;
      cmd_if.cmd_width = 16'd1720;
      guard = 0;
      while (busy && guard < 50) begin
         check("scan_rdy_low", int'(cmd_if.cmd_ready), 0);
         tick = (guard == 1);
         guard++;
         @(posedge clk); #1;
      end
      tick = 1'b0;
      check("scan_len", guard, NUM_CH);
      model_tick();
      check("scan_rdy_back", int'(cmd_if.cmd_ready), 1);
      @(posedge clk); #1;
      cmd_if.cmd_valid = 1'b0;
      m_tgt[4] = 1720;
      check("extra_tick_ignored", int'(busy), 0);
      @(posedge clk); #1;
      check_all("held_cmd");
      do_tick("held_tick");

      // Randomized mix of commands, ticks and simultaneous pairs
      for (int r = 0; r < 40; r++) begin
         int sel = $urandom_range(0, 3);
         int ch  = $urandom_range(0, 7);
         int w   = (($urandom_range(0, 3) == 0) ? $urandom_range(900, 2600) : $urandom_range(MIN_W, MAX_W));
         if (sel == 0)      run_cmd("rnd_cmd", ch, w, 0);
         else if (sel == 1) run_cmd("rnd_cmdtick", ch, w, 1);
         else               do_tick("rnd_tick");
      end

      // Reset on the third scan cycle
      run_cmd("pre_rst", 1, 1900, 0);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_mid_busy_pre", int'(busy), 1);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk); #1;
      check("rst_hold_busy", int'(busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_all("post_rst");
      do_tick("post_rst_tick");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
